// File: rtl/serv_irq_pkg.sv
// serv_irq_pkg -- shared definitions for the SERV interrupt arbiter.
// Holds the machine interrupt cause codes, the mie bit positions inside the
// bit-serial CSR word, the arbiter FSM encoding and the priority picker.

package serv_irq_pkg;

    // Exception codes reported in mcause for each machine interrupt source
    localparam logic [3:0] CAUSE_MSI  = 4'd3;
    localparam logic [3:0] CAUSE_MTI  = 4'd7;
    localparam logic [3:0] CAUSE_MEI  = 4'd11;
    localparam logic [3:0] CAUSE_NONE = 4'd0;

    // Bit positions of the enable bits inside mie (serial step index)
    localparam logic [4:0] MIE_MSIE_IDX = 5'd3;
    localparam logic [4:0] MIE_MTIE_IDX = 5'd7;
    localparam logic [4:0] MIE_MEIE_IDX = 5'd11;

    // Serial step at which the mcause interrupt flag (MSB) is shifted out
    localparam logic [4:0] CNT_MCAUSE_MSB = 5'd31;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Fixed-priority pick: external beats software beats timer
    function automatic logic [3:0] irq_pick_cause(
        input logic mei,
        input logic msi,
        input logic mti
    );
        logic [3:0] cause;
        cause = CAUSE_NONE;
        if (mei) begin
            cause = CAUSE_MEI;
        end else if (msi) begin
            cause = CAUSE_MSI;
        end else if (mti) begin
            cause = CAUSE_MTI;
        end else begin
            cause = CAUSE_NONE;
        end
        return cause;
    endfunction

endpackage

// File: rtl/serv_irq_sync.sv
// serv_irq_sync -- N-stage single-bit synchronizer for asynchronous
// interrupt levels. STAGES must be at least 2.

module serv_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw level one stage further along the chain each clock
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_d};
    end

    // Synchronizer flops, cleared by reset so no stale level survives it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/serv_irq_arb.sv
// serv_irq_arb -- machine interrupt arbiter for the bit-serial SERV core.
// Holds the MSIE/MTIE/MEIE enables, synchronizes the asynchronous sources,
// picks the highest-priority pending interrupt and walks an
// IDLE -> REQ -> SERVICE handshake with the core, locking the cause code
// for the whole request/service window.
// Build option: define SERV_IRQ_EXT_EN to include the external interrupt
// (meip) path; without it MEIE is hardwired to 0 and i_meip is ignored.

module serv_irq_arb
    import serv_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_mtip,
    input  logic       i_msip,
    input  logic       i_meip,
    input  logic       i_mstatus_mie,
    input  logic       i_mie_en,
    input  logic       i_en,
    input  logic [4:0] i_cnt,
    input  logic       i_csr_in,
    output logic       o_mie_q,
    input  logic       i_trap_taken,
    input  logic       i_mret,
    output logic       o_irq_req,
    output logic       o_new_irq,
    output logic [3:0] o_cause,
    output logic       o_cause_q
);

    // ------------------------------------------------------------------
    // Source synchronization
    // ------------------------------------------------------------------
    logic msip_sync_s;
    logic meip_sync_s;

    serv_irq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync_msip (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_msip),
        .o_q     (msip_sync_s)
    );

`ifdef SERV_IRQ_EXT_EN
    serv_irq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync_meip (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_meip),
        .o_q     (meip_sync_s)
    );
`else
    logic unused_meip_s;
    assign unused_meip_s = i_meip;
    assign meip_sync_s   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // mie enable bits
    // ------------------------------------------------------------------
    logic mie_msie_q;
    logic mie_msie_d;
    logic mie_mtie_q;
    logic mie_mtie_d;
    logic mie_meie_s;
    logic mie_wr_s;

    assign mie_wr_s = i_mie_en & i_en;

    // Capture the serial write bit when the step lands on MSIE or MTIE
    always_comb begin
        mie_msie_d = mie_msie_q;
        mie_mtie_d = mie_mtie_q;
        if (mie_wr_s && (i_cnt == MIE_MSIE_IDX)) begin
            mie_msie_d = i_csr_in;
        end else begin
            mie_msie_d = mie_msie_q;
        end
        if (mie_wr_s && (i_cnt == MIE_MTIE_IDX)) begin
            mie_mtie_d = i_csr_in;
        end else begin
            mie_mtie_d = mie_mtie_q;
        end
    end

    // MSIE/MTIE storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mie_msie_q <= 1'b0;
            mie_mtie_q <= 1'b0;
        end else begin
            mie_msie_q <= mie_msie_d;
            mie_mtie_q <= mie_mtie_d;
        end
    end

`ifdef SERV_IRQ_EXT_EN
    logic mie_meie_q;
    logic mie_meie_d;

    // Capture the serial write bit when the step lands on MEIE
    always_comb begin
        mie_meie_d = mie_meie_q;
        if (mie_wr_s && (i_cnt == MIE_MEIE_IDX)) begin
            mie_meie_d = i_csr_in;
        end else begin
            mie_meie_d = mie_meie_q;
        end
    end

    // MEIE storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mie_meie_q <= 1'b0;
        end else begin
            mie_meie_q <= mie_meie_d;
        end
    end

    assign mie_meie_s = mie_meie_q;
`else
    assign mie_meie_s = 1'b0;
`endif

    logic mie_rd_s;

    // Serial mie readback: only the three implemented bits are non-zero
    always_comb begin
        mie_rd_s = 1'b0;
        if (mie_wr_s) begin
            case (i_cnt)
                MIE_MSIE_IDX: mie_rd_s = mie_msie_q;
                MIE_MTIE_IDX: mie_rd_s = mie_mtie_q;
                MIE_MEIE_IDX: mie_rd_s = mie_meie_s;
                default:      mie_rd_s = 1'b0;
            endcase
        end else begin
            mie_rd_s = 1'b0;
        end
    end

    assign o_mie_q = mie_rd_s;

    // ------------------------------------------------------------------
    // Pending / eligibility / priority
    // ------------------------------------------------------------------
    logic       pend_msi_s;
    logic       pend_mti_s;
    logic       pend_mei_s;
    logic       eligible_s;
    logic [3:0] win_cause_s;

    assign pend_msi_s  = msip_sync_s & mie_msie_q;
    assign pend_mti_s  = i_mtip      & mie_mtie_q;
    assign pend_mei_s  = meip_sync_s & mie_meie_s;
    assign eligible_s  = (pend_msi_s | pend_mti_s | pend_mei_s) & i_mstatus_mie;
    assign win_cause_s = irq_pick_cause(pend_mei_s, pend_msi_s, pend_mti_s);

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    irq_state_e state_q;
    irq_state_e state_d;
    logic       irq_req_q;
    logic       irq_req_d;
    logic       new_irq_q;
    logic       new_irq_d;
    logic [3:0] cause_q;
    logic [3:0] cause_d;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a trap in IDLE is a synchronous exception and goes
    // straight to SERVICE; mret only matters once the trap was taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_trap_taken) begin
                    state_d = ST_SERVICE;
                end else if (eligible_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_trap_taken) begin
                    state_d = ST_SERVICE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (i_mret) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs for the coming cycle; the cause is locked only when a new
    // request is raised and held through REQ and SERVICE
    always_comb begin
        irq_req_d = 1'b0;
        new_irq_d = 1'b0;
        cause_d   = cause_q;
        if (state_d == ST_REQ) begin
            irq_req_d = 1'b1;
        end else begin
            irq_req_d = 1'b0;
        end
        if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            new_irq_d = 1'b1;
            cause_d   = win_cause_s;
        end else begin
            new_irq_d = 1'b0;
            cause_d   = cause_q;
        end
    end

    // Registered request outputs; async reset drops the request at once
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_req_q <= 1'b0;
            new_irq_q <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            irq_req_q <= irq_req_d;
            new_irq_q <= new_irq_d;
            cause_q   <= cause_d;
        end
    end

    assign o_irq_req = irq_req_q;
    assign o_new_irq = new_irq_q;
    assign o_cause   = cause_q;

    // ------------------------------------------------------------------
    // Serial mcause
    // ------------------------------------------------------------------
    logic cause_ser_s;

    // Low nibble carries the code; bit 31 flags an interrupt in flight
    always_comb begin
        cause_ser_s = 1'b0;
        if (i_cnt < 5'd4) begin
            cause_ser_s = cause_q[i_cnt[1:0]];
        end else if (i_cnt == CNT_MCAUSE_MSB) begin
            cause_ser_s = (state_q != ST_IDLE);
        end else begin
            cause_ser_s = 1'b0;
        end
    end

    assign o_cause_q = cause_ser_s;

endmodule

// File: tb/tb_serv_irq_arb.sv
// tb_serv_irq_arb -- self-checking bench for serv_irq_arb.
// A behavioural model (delay-line queues, a mie word, a mode number) is
// stepped on every rising edge and compared with the DUT one time unit
// later; directed sequences add literal expectations at key points.
// Honours SERV_IRQ_EXT_EN the same way the design does.

module tb_serv_irq_arb;

    localparam int S = 2;
`ifdef SERV_IRQ_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mtip, msip, meip, mstatus_mie, mie_en, en, csr_in;
    logic [4:0] cnt;
    logic       trap, mret;
    logic       mie_q, irq_req, new_irq, cause_q;
    logic [3:0] cause;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serv_irq_arb #(.SYNC_STAGES(S)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_mtip        (mtip),
        .i_msip        (msip),
        .i_meip        (meip),
        .i_mstatus_mie (mstatus_mie),
        .i_mie_en      (mie_en),
        .i_en          (en),
        .i_cnt         (cnt),
        .i_csr_in      (csr_in),
        .o_mie_q       (mie_q),
        .i_trap_taken  (trap),
        .i_mret        (mret),
        .o_irq_req     (irq_req),
        .o_new_irq     (new_irq),
        .o_cause       (cause),
        .o_cause_q     (cause_q)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        q_msip[$];
    bit        q_meip[$];
    bit [11:0] m_mie;
    int        m_mode;   // 0 idle, 1 requesting, 2 in handler
    int        m_cause;
    bit        m_new;

    task automatic model_reset();
        q_msip.delete();
        q_meip.delete();
        for (int i = 0; i < S; i++) begin
            q_msip.push_back(1'b0);
            q_meip.push_back(1'b0);
        end
        m_mie   = 12'h000;
        m_mode  = 0;
        m_cause = 0;
        m_new   = 1'b0;
    endtask

    task automatic model_edge();
        bit mei, msi, mti;
        int win;
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        mei = EXT && q_meip[0] && m_mie[11];
        msi = q_msip[0] && m_mie[3];
        mti = mtip && m_mie[7];
        win = mei ? 11 : (msi ? 3 : (mti ? 7 : 0));
        m_new = 1'b0;
        if (m_mode == 0) begin
            if (trap) m_mode = 2;
            else if (win != 0 && mstatus_mie) begin
                m_mode  = 1;
                m_cause = win;
                m_new   = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (trap) m_mode = 2;
        end else begin
            if (mret) m_mode = 0;
        end
        void'(q_msip.pop_front());
        void'(q_meip.pop_front());
        q_msip.push_back(msip);
        q_meip.push_back(meip);
        if (mie_en && en && (cnt == 3 || cnt == 7 || (cnt == 11 && EXT)))
            m_mie[cnt] = csr_in;
    endtask

    // Compare process: every cycle, just after the rising edge
    initial begin
        int exp_mq, exp_cq;
        model_reset();
        forever begin
            @(posedge clk);
            model_edge();
            #1;
            exp_mq = (mie_en && en && (cnt == 3 || cnt == 7 || cnt == 11)) ? int'(m_mie[cnt]) : 0;
            if (cnt < 4) exp_cq = (m_cause >> cnt) & 1;
            else if (cnt == 31) exp_cq = (m_mode != 0) ? 1 : 0;
            else exp_cq = 0;
            check("model irq_req", int'(irq_req), (m_mode == 1) ? 1 : 0);
            check("model new_irq", int'(new_irq), int'(m_new));
            check("model cause",   int'(cause),   m_cause);
            check("model mie_q",   int'(mie_q),   exp_mq);
            check("model cause_q", int'(cause_q), exp_cq);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic mie_write(input logic [11:0] val);
        for (int c = 0; c < 32; c++) begin
            mie_en = 1'b1; en = 1'b1; cnt = 5'(c);
            csr_in = (c < 12) ? val[c] : 1'b0;
            @(negedge clk);
        end
        mie_en = 1'b0; en = 1'b0; cnt = 5'd0; csr_in = 1'b0;
    endtask

    // Read mie serially while writing the same value back
    task automatic mie_read(input logic [11:0] val);
        int exp;
        for (int c = 0; c < 32; c++) begin
            mie_en = 1'b1; en = 1'b1; cnt = 5'(c);
            csr_in = (c < 12) ? val[c] : 1'b0;
            #2;
            exp = (c == 3 || c == 7) ? 1 : ((c == 11) ? int'(EXT) : 0);
            check($sformatf("mie read bit %0d", c), int'(mie_q), exp);
            @(negedge clk);
        end
        mie_en = 1'b0; en = 1'b0; cnt = 5'd0; csr_in = 1'b0;
    endtask

    task automatic pulse_trap();
        trap = 1'b1; @(negedge clk); trap = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1; @(negedge clk); mret = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] exp_c7;
        rst_n = 1'b0;
        mtip = 1'b0; msip = 1'b0; meip = 1'b0; mstatus_mie = 1'b0;
        mie_en = 1'b0; en = 1'b0; cnt = 5'd0; csr_in = 1'b0;
        trap = 1'b0; mret = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset irq_req", int'(irq_req), 0);
        check("reset cause",   int'(cause),   0);
        check("reset new_irq", int'(new_irq), 0);
        after_edge();
        check("first cycle no req", int'(irq_req), 0);
        @(negedge clk);

        // enable all three sources and read them back
        mie_write(12'h888);
        mie_read(12'h888);

        // timer: one cycle to request, cause 7
        mstatus_mie = 1'b1;
        mtip = 1'b1;
        after_edge();
        check("mti irq_req", int'(irq_req), 1);
        check("mti new_irq", int'(new_irq), 1);
        check("mti cause",   int'(cause),   7);
        after_edge();
        check("mti new_irq once", int'(new_irq), 0);
        check("mti hold req",     int'(irq_req), 1);
        @(negedge clk);

        // serial cause: 7 = 0111, bit 31 set while requesting
        exp_c7 = 4'b0111;
        cnt = 5'd31; #2; check("cause_q bit31", int'(cause_q), 1);
        for (int c = 0; c < 4; c++) begin
            cnt = 5'(c); #1;
            check($sformatf("cause_q bit%0d", c), int'(cause_q), int'(exp_c7[c]));
        end
        cnt = 5'd0;
        @(negedge clk);

        // higher source while requesting must not change the locked cause
        meip = 1'b1;
        repeat (5) @(negedge clk);
        check("lock cause vs meip", int'(cause), 7);
        meip = 1'b0;
        repeat (4) @(negedge clk);

        // trap then mret with mtip still high: one idle cycle, then REQ again
        trap = 1'b1;
        after_edge();
        check("svc irq_req", int'(irq_req), 0);
        @(negedge clk); trap = 1'b0;
        repeat (2) @(negedge clk);
        check("svc holds", int'(irq_req), 0);
        mret = 1'b1;
        after_edge();
        check("idle after mret", int'(irq_req), 0);
        @(negedge clk); mret = 1'b0;
        after_edge();
        check("re-req irq_req", int'(irq_req), 1);
        check("re-req new_irq", int'(new_irq), 1);
        check("re-req cause",   int'(cause),   7);
        @(negedge clk);
        mtip = 1'b0;
        pulse_trap();
        pulse_mret();
        repeat (2) @(negedge clk);
        check("back idle", int'(irq_req), 0);

        // msip and meip together: S+1 edges to request
        msip = 1'b1; meip = 1'b1;
        after_edge(); check("sync edge1", int'(irq_req), 0);
        after_edge(); check("sync edge2", int'(irq_req), 0);
        after_edge();
        check("sync edge3 req", int'(irq_req), 1);
        check("ext prio cause", int'(cause), EXT ? 11 : 3);
        @(negedge clk);
        pulse_trap();
        msip = 1'b0; meip = 1'b0;
        repeat (4) @(negedge clk);
        pulse_mret();
        @(negedge clk);

        // exception trap from idle keeps the old cause; mret in idle ignored
        pulse_trap();
        check("exc cause kept", int'(cause), EXT ? 11 : 3);
        cnt = 5'd31; #1; check("exc bit31", int'(cause_q), 1);
        cnt = 5'd0;
        pulse_mret();
        pulse_mret();
        check("mret idle ignored", int'(irq_req), 0);

        // global enable gates requests
        mstatus_mie = 1'b0;
        mtip = 1'b1;
        repeat (3) @(negedge clk);
        check("mstatus gate", int'(irq_req), 0);
        mstatus_mie = 1'b1;
        after_edge();
        check("mstatus open", int'(irq_req), 1);
        @(negedge clk);

        // asynchronous reset in the middle of a request
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst irq_req", int'(irq_req), 0);
        check("async rst cause",   int'(cause),   0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        after_edge();
        check("post rst no req", int'(irq_req), 0);
        @(negedge clk);
        cnt = 5'd31; #1;
        check("post rst idle", int'(cause_q), 0);
        cnt = 5'd0;
        repeat (3) @(negedge clk);
        check("post rst mie cleared", int'(irq_req), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serv_irq_arb.md
SERV_IRQ_ARB -- requirements
Module: serv_irq_arb

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for i_meip and i_msip (legal values 2..3).
REQ-002 SHALL have ports, clock and reset first:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_mtip, in, 1: timer irq level, synchronous to i_clk.
- i_msip, in, 1: software irq level, asynchronous.
- i_meip, in, 1: external irq level, asynchronous.
- i_mstatus_mie, in, 1: global enable from CSR block.
- i_mie_en, in, 1: mie CSR access active.
- i_en, in, 1: bit-serial step enable.
- i_cnt, in, 5: bit-serial position.
- i_csr_in, in, 1: serial CSR write data, LSB first.
- o_mie_q, out, 1: serial mie readback.
- i_trap_taken, in, 1: core entered trap.
- i_mret, in, 1: mret executing.
- o_irq_req, out, 1: interrupt request to core.
- o_new_irq, out, 1: one-cycle pulse on o_irq_req rise.
- o_cause, out, 4: locked exception code.
- o_cause_q, out, 1: serial mcause bit.

Function
REQ-003 SHALL synchronize i_msip and i_meip through SYNC_STAGES flops; i_mtip is used directly.
REQ-004 SHALL hold mie bits MSIE(3), MTIE(7), MEIE(11), written from i_csr_in when i_mie_en & i_en & i_cnt equals the bit index.
REQ-005 o_mie_q SHALL equal the addressed mie bit when i_mie_en & i_en & i_cnt is 3, 7 or 11, else 0.
REQ-006 pending[k] SHALL equal synchronized source k AND its mie bit; eligible SHALL be (pending != 0) & i_mstatus_mie.
REQ-007 Priority SHALL be MEI (11) > MSI (3) > MTI (7).
REQ-008 FSM states SHALL be IDLE, REQ and SERVICE.
REQ-009 IDLE->REQ when eligible; on that edge o_cause SHALL lock to the winning code.
REQ-010 In REQ, o_irq_req SHALL be 1 and o_cause SHALL stay constant even if the source drops or a higher source rises.
REQ-011 REQ->SERVICE on i_trap_taken.
REQ-012 SERVICE->IDLE on i_mret; o_irq_req SHALL be 0 in SERVICE and IDLE.
REQ-013 i_trap_taken in IDLE (exception trap) SHALL go to SERVICE with o_cause unchanged; i_mret in IDLE or REQ SHALL be ignored.
REQ-014 o_new_irq SHALL be 1 exactly in the first cycle of REQ.
REQ-015 o_cause_q SHALL be o_cause[i_cnt] for i_cnt 0..3, and 1 at i_cnt==31 while in REQ or SERVICE, else 0.
REQ-016 Latency: a source change reaches o_irq_req in SYNC_STAGES+1 cycles (msip/meip) and 1 cycle (mtip).

Reset
REQ-017 On i_rst_n low (asynchronous) SHALL force: FSM IDLE, mie bits 0, synchronizers 0, o_cause 0, o_irq_req 0, o_new_irq 0; reset asserted mid-REQ SHALL drop o_irq_req immediately.
REQ-018 Release SHALL be clean on the next i_clk edge; no request is generated in the first cycle after release.

Configuration
REQ-019 Macro SERV_IRQ_EXT_EN defined: the external source path is present per REQ-003..007.
REQ-020 Macro SERV_IRQ_EXT_EN undefined: no meip synchronizer; MEIE reads 0 and ignores writes; pending[MEI] is 0; i_meip is unused.

Structure
REQ-021 A shared package (serv_irq_pkg) SHALL hold the cause codes MEI=11, MSI=3, MTI=7, the mie bit indices and the FSM state encoding.
REQ-022 Sub-module serv_irq_sync (an N-stage single-bit synchronizer) SHALL be instantiated once per asynchronous source.

Verification
REQ-023 The bench SHALL cover:
- MTIE=1, mstatus_mie=1, mtip 0->1: o_irq_req=1 and o_new_irq pulse next cycle, o_cause=7.
- meip and msip both raised, all enabled: o_cause=11 after SYNC_STAGES+1 cycles.
- In REQ with cause 7, raise meip: o_cause stays 7 until i_trap_taken.
- i_trap_taken, then i_mret with mtip still high: REQ re-entered 1 cycle after mret, o_cause=7.
- Serial write 0x888 to mie, serial read: o_mie_q=1 at cnt 3/7/11, 0 elsewhere; with SERV_IRQ_EXT_EN off, bit 11 reads 0.
- Assert i_rst_n=0 mid-REQ: o_irq_req=0 without a clock edge, and the FSM is IDLE after release.
